// File: rtl/decode_stage.sv
// picoMIPS instruction-decode stage: splits the instruction into opcode/imm/offset,
// widens imm (zero) and offset (sign), and carries it across a 2-entry skid buffer.

package cpu_pkg;
   parameter int I_WIDTH      = 12;
   parameter int OPCODE_WIDTH = 6;
endpackage

module decode_stage #(
   parameter int I_WIDTH      = cpu_pkg::I_WIDTH,
   parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH,
   parameter int IMM_W        = 3,
   parameter int OFF_W        = 3,
   parameter int DATA_W       = 8,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [I_WIDTH-1:0]      in_instr,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OPCODE_WIDTH-1:0] out_opcode,
   output logic [DATA_W-1:0]       out_imm,
   output logic [DATA_W-1:0]       out_offset,
   output logic [I_WIDTH-1:0]      out_instr,
   output logic [CNT_W-1:0]        stall_cnt
);

   if (OPCODE_WIDTH + IMM_W + OFF_W != I_WIDTH) begin : g_bad_layout
      $error("decode_stage: OPCODE_WIDTH+IMM_W+OFF_W must equal I_WIDTH");
   end
   if (DATA_W < IMM_W || DATA_W < OFF_W) begin : g_bad_data_w
      $error("decode_stage: DATA_W must be at least max(IMM_W, OFF_W)");
   end

   // Handshake: a transfer happens on an edge where valid && ready are both high;
   // the producer holds its payload stable until that edge, ready never waits on valid.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0] opcode;
      logic [DATA_W-1:0]       imm;
      logic [DATA_W-1:0]       offset;
      logic [I_WIDTH-1:0]      instr;
   } dec_t;

   state_t state, state_nxt;
   dec_t   dec_in, m_q, s_q;
   logic   in_xfer, out_xfer;
   logic   load_m, load_s, shift_s;

   always_comb begin
      dec_in.opcode = in_instr[I_WIDTH-1 -: OPCODE_WIDTH];
      dec_in.imm    = {{(DATA_W-IMM_W){1'b0}}, in_instr[OFF_W +: IMM_W]};
      dec_in.offset = {{(DATA_W-OFF_W){in_instr[OFF_W-1]}}, in_instr[OFF_W-1:0]};
      dec_in.instr  = in_instr;
   end

   assign out_valid = (state != EMPTY);
   assign in_xfer   = in_valid && in_ready && !flush;
   assign out_xfer  = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      load_m    = 1'b0;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      case (state)
         EMPTY: begin
            if (in_xfer) begin
               load_m    = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               load_m = 1'b1;
            end else if (in_xfer) begin
               load_s    = 1'b1;
               state_nxt = FULL;
            end else if (out_xfer) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               shift_s   = 1'b1;
               state_nxt = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush wins; a concurrent output transfer is still treated as consumed.
      if (flush) begin
         state_nxt = EMPTY;
         load_m    = 1'b0;
         load_s    = 1'b0;
         shift_s   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q <= '0;
         s_q <= '0;
      end else begin
         if (load_m) begin
            m_q <= dec_in;
         end else if (shift_s) begin
            m_q <= s_q;
         end
         if (load_s) begin
            s_q <= dec_in;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign out_opcode = m_q.opcode;
   assign out_imm    = m_q.imm;
   assign out_offset = m_q.offset;
   assign out_instr  = m_q.instr;

endmodule
